// File: rtl/gcd_pkg.sv
// Shared definitions for the GCD core and its job feeder: default width
// and the feeder's state encoding.
package gcd_pkg;

   localparam int GCD_W = 4;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CLR  = 2'd1,
      RUN  = 2'd2
   } state_t;

endpackage

// File: rtl/gcd_job_feeder_if.sv
// User-facing side of the job feeder: operand push, result hand-off and
// sticky error flags. The feeder takes the slave modport.
interface gcd_job_feeder_if #(
   parameter int W = gcd_pkg::GCD_W
);
   logic         push;
   logic [W-1:0] push_x;
   logic [W-1:0] push_y;
   logic         full;
   logic         empty;
   logic         res_valid;
   logic [W-1:0] res_x;
   logic [W-1:0] res_y;
   logic [W-1:0] res_gcd;
   logic         res_ack;
   logic         err_zero;
   logic         err_tmo;

   modport master (
      output push, push_x, push_y, res_ack,
      input  full, empty, res_valid, res_x, res_y, res_gcd, err_zero, err_tmo
   );

   modport slave (
      input  push, push_x, push_y, res_ack,
      output full, empty, res_valid, res_x, res_y, res_gcd, err_zero, err_tmo
   );
endinterface

// File: rtl/gcd_pair_fifo.sv
// Small synchronous FIFO of {x,y} operand pairs. Pointers carry one extra
// wrap bit so full and empty are told apart without a counter. The head is
// read combinationally so the core sees the operands as soon as an entry
// lands; at this depth the storage is a plain register file.
module gcd_pair_fifo
   import gcd_pkg::*;
#(
   parameter int W     = GCD_W,
   parameter int DEPTH = 4
) (
   input  logic           clk,
   input  logic           reset,
   input  logic           push,
   input  logic           pop,
   input  logic [2*W-1:0] din,
   output logic           full,
   output logic           empty,
   output logic [2*W-1:0] head
);
   localparam int AW = $clog2(DEPTH);

   logic [AW:0]    wr_ptr_reg;
   logic [AW:0]    rd_ptr_reg;
   logic [2*W-1:0] mem_reg [DEPTH];
   logic           push_ok;
   logic           pop_ok;

   assign full    = (wr_ptr_reg[AW] != rd_ptr_reg[AW]) &&
                    (wr_ptr_reg[AW-1:0] == rd_ptr_reg[AW-1:0]);
   assign empty   = (wr_ptr_reg == rd_ptr_reg);
   assign push_ok = push & ~full;
   assign pop_ok  = pop & ~empty;
   assign head    = mem_reg[rd_ptr_reg[AW-1:0]];

   // Pointer update; push and pop may happen in the same cycle.
   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr_reg <= '0;
         rd_ptr_reg <= '0;
      end else begin
         if (push_ok) wr_ptr_reg <= wr_ptr_reg + 1'b1;
         if (pop_ok)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
      end
   end

   // One write-enabled register per entry; contents need no reset.
   generate
      for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
         always_ff @(posedge clk) begin
            if (push_ok && (wr_ptr_reg[AW-1:0] == AW'(gi)))
               mem_reg[gi] <= din;
         end
      end
   endgenerate
endmodule

// File: rtl/gcd_job_feeder.sv
// Queues operand pairs and runs them through the GCD core one at a time:
// pulse the core's reset, hold Start with the operands until Done (or a
// timeout), then capture the result. Zero operands are refused because
// they would never terminate the core's subtract loop.
module gcd_job_feeder
   import gcd_pkg::*;
#(
   parameter int W       = GCD_W,
   parameter int DEPTH   = 4,
   parameter int TIMEOUT = 255
) (
   input  logic         clk,
   input  logic         reset,
   gcd_job_feeder_if.slave job,
   output logic         core_rst,
   output logic         core_start,
   output logic [W-1:0] core_x,
   output logic [W-1:0] core_y,
   input  logic         core_done,
   input  logic [W-1:0] core_gcd
);
   localparam int TW = $clog2(TIMEOUT + 1);
   localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);

   state_t         state_reg;
   logic [TW-1:0]  timer_reg;
   logic           res_valid_reg;
   logic [W-1:0]   res_x_reg;
   logic [W-1:0]   res_y_reg;
   logic [W-1:0]   res_gcd_reg;
   logic           err_zero_reg;
   logic           err_tmo_reg;

   logic           push_zero;
   logic           fifo_push;
   logic           fifo_pop;
   logic           fifo_full;
   logic           fifo_empty;
   logic [2*W-1:0] fifo_head;
   logic           run_timeout;

   assign push_zero   = job.push & ((job.push_x == '0) | (job.push_y == '0));
   assign fifo_push   = job.push & ~push_zero;
   assign run_timeout = (timer_reg == TMO_LAST);
   // A job leaves the queue whether it finished or timed out.
   assign fifo_pop    = (state_reg == RUN) & (core_done | run_timeout);

   gcd_pair_fifo #(
      .W     (W),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk   (clk),
      .reset (reset),
      .push  (fifo_push),
      .pop   (fifo_pop),
      .din   ({job.push_x, job.push_y}),
      .full  (fifo_full),
      .empty (fifo_empty),
      .head  (fifo_head)
   );

   // Core drive is a pure function of the registered state; reset reaches
   // the core directly so it is cleared in the same cycle.
   assign core_rst   = reset | (state_reg == CLR);
   assign core_start = (state_reg == RUN);
   assign core_x     = fifo_head[2*W-1:W];
   assign core_y     = fifo_head[W-1:0];

   assign job.full      = fifo_full;
   assign job.empty     = fifo_empty;
   assign job.res_valid = res_valid_reg;
   assign job.res_x     = res_x_reg;
   assign job.res_y     = res_y_reg;
   assign job.res_gcd   = res_gcd_reg;
   assign job.err_zero  = err_zero_reg;
   assign job.err_tmo   = err_tmo_reg;

   // Sticky flag for refused zero-operand pushes.
   always_ff @(posedge clk) begin
      if (reset)          err_zero_reg <= 1'b0;
      else if (push_zero) err_zero_reg <= 1'b1;
   end

   // Job sequencer: IDLE -> CLR (core reset) -> RUN (until done/timeout).
   always_ff @(posedge clk) begin
      if (reset) begin
         state_reg     <= IDLE;
         timer_reg     <= '0;
         res_valid_reg <= 1'b0;
         res_x_reg     <= '0;
         res_y_reg     <= '0;
         res_gcd_reg   <= '0;
         err_tmo_reg   <= 1'b0;
      end else begin
         if (job.res_ack && res_valid_reg)
            res_valid_reg <= 1'b0;
         case (state_reg)
            IDLE: begin
               // A pending result holds off the next job.
               if (!fifo_empty && !res_valid_reg)
                  state_reg <= CLR;
            end
            CLR: begin
               // Done from the previous job is cleared by this edge.
               timer_reg <= '0;
               state_reg <= RUN;
            end
            RUN: begin
               // Stops at TIMEOUT at most, so the counter never wraps.
               timer_reg <= timer_reg + 1'b1;
               if (core_done) begin
                  res_x_reg     <= core_x;
                  res_y_reg     <= core_y;
                  res_gcd_reg   <= core_gcd;
                  res_valid_reg <= 1'b1;
                  state_reg     <= IDLE;
               end else if (run_timeout) begin
                  err_tmo_reg <= 1'b1;
                  state_reg   <= IDLE;
               end
            end
            default: state_reg <= IDLE;
         endcase
      end
   end
endmodule
